// File: rtl/game_sprite_pkg.sv
// game_sprite_pkg: sprite and screen geometry, colour type, flash states and the sprite bitmap.
package game_sprite_pkg;
    localparam int SPRITE_WIDTH = 8;
    localparam int SPRITE_HEIGHT = 8;
    localparam int screen_width = 640;
    localparam int screen_height = 480;
    localparam int w_x = $clog2(screen_width);
    localparam int w_y = $clog2(screen_height);
    localparam int RGB_WIDTH = 3;
    localparam int FLASH_FRAMES = 8;
    localparam int log_w = $clog2(SPRITE_WIDTH);
    localparam int log_h = $clog2(SPRITE_HEIGHT);
    localparam int rom_aw = log_w + log_h;
    typedef logic [RGB_WIDTH-1:0] rgb_t;
    typedef enum logic {IDLE, FLASH} flash_state_t;
    localparam rgb_t TRANSPARENT = '0;
    localparam rgb_t FLASH_COLOR = '1;
    localparam rgb_t RED = rgb_t'(4);
    localparam rgb_t BLUE = rgb_t'(1);
    // Bitmap: left column red, right column blue, a diagonal transparent lattice inside.
    function automatic rgb_t sprite_pixel(input logic [rom_aw-1:0] addr);
        int r, c;
        r = int'(addr[rom_aw-1:log_w]);
        c = int'(addr[log_w-1:0]);
        if (c == 0) return RED;
        if (c == SPRITE_WIDTH - 1) return BLUE;
        return (r + c) % 3 == 0 ? TRANSPARENT : rgb_t'((r * 3 + c) % 6 + 1);
    endfunction
endpackage

// File: rtl/game_sprite_display_if.sv
// game_sprite_display_if: raster/sprite inputs and mixer-facing pixel outputs.
interface game_sprite_display_if;
    import game_sprite_pkg::*;
    logic frame_start;
    logic pix_valid;
    logic [w_x-1:0] pix_x;
    logic [w_y-1:0] pix_y;
    logic [w_x-1:0] sprite_x;
    logic [w_y-1:0] sprite_y;
    logic sprite_dx_neg;
    logic hit_wall;
    logic out_valid;
    logic out_within;
    rgb_t out_rgb;
    modport master(output frame_start, pix_valid, pix_x, pix_y, sprite_x, sprite_y, sprite_dx_neg,
                   hit_wall, input out_valid, out_within, out_rgb);
    modport slave(input frame_start, pix_valid, pix_x, pix_y, sprite_x, sprite_y, sprite_dx_neg,
                  hit_wall, output out_valid, out_within, out_rgb);
endinterface

// File: rtl/game_sprite_rom.sv
// game_sprite_rom: synchronous-read sprite bitmap, one cycle read latency.
module game_sprite_rom
    import game_sprite_pkg::*;
(
    input  logic              clk,
    input  logic [rom_aw-1:0] addr,
    output rgb_t              data
);
    always_ff @(posedge clk) data <= sprite_pixel(addr);
endmodule

// File: rtl/game_sprite_display.sv
// game_sprite_display: per-frame latched sprite position, 2-cycle bitmap pipeline, hit-wall flash.
// Optional GAME_SPRITE_FLIP_EN: horizontal mirroring from the latched sprite_dx_neg.
module game_sprite_display
    import game_sprite_pkg::*;
(
    input logic clk,
    input logic rst,
    game_sprite_display_if.slave bus
);
    logic [w_x-1:0] shadow_x;
    logic [w_y-1:0] shadow_y;
    logic [w_x:0] rel_x;
    logic [w_y:0] rel_y;
    logic [log_w-1:0] col;
    logic [rom_aw-1:0] addr;
    logic in_box, in_box_d1, in_box_d2, valid_d1, valid_d2, hit_d, rise;
    rgb_t rom_data;
    flash_state_t state, state_next;
    logic [7:0] cnt, cnt_next;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            shadow_x <= '0;
            shadow_y <= '0;
        end else if (bus.frame_start) begin
            shadow_x <= bus.sprite_x;
            shadow_y <= bus.sprite_y;
        end

`ifdef GAME_SPRITE_FLIP_EN
    logic flip;
    always_ff @(posedge clk or posedge rst)
        if (rst) flip <= 1'b0;
        else if (bus.frame_start) flip <= bus.sprite_dx_neg;
    assign col = flip ? log_w'(SPRITE_WIDTH - 1) - rel_x[log_w-1:0] : rel_x[log_w-1:0];
`else
    assign col = rel_x[log_w-1:0];
`endif

    // Extra top bit is the borrow: raster left of / above the sprite never wraps into the box.
    assign rel_x = {1'b0, bus.pix_x} - {1'b0, shadow_x};
    assign rel_y = {1'b0, bus.pix_y} - {1'b0, shadow_y};
    assign in_box = bus.pix_valid & ~rel_x[w_x] & ~rel_y[w_y] &
                    (rel_x[w_x-1:0] < w_x'(SPRITE_WIDTH)) & (rel_y[w_y-1:0] < w_y'(SPRITE_HEIGHT));

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            addr <= '0;
            in_box_d1 <= 1'b0;
            valid_d1 <= 1'b0;
            in_box_d2 <= 1'b0;
            valid_d2 <= 1'b0;
        end else begin
            addr <= {rel_y[log_h-1:0], col};
            in_box_d1 <= in_box;
            valid_d1 <= bus.pix_valid;
            in_box_d2 <= in_box_d1;
            valid_d2 <= valid_d1;
        end

    game_sprite_rom rom (.clk(clk), .addr(addr), .data(rom_data));

    assign rise = bus.hit_wall & ~hit_d;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            hit_d <= 1'b0;
        end else begin
            state <= state_next;
            cnt <= cnt_next;
            hit_d <= bus.hit_wall;
        end

    // A fresh hit edge always reloads, even on a frame_start cycle.
    always_comb begin
        state_next = state;
        cnt_next = cnt;
        if (rise) begin
            state_next = FLASH;
            cnt_next = 8'(FLASH_FRAMES);
        end else if (state == FLASH && bus.frame_start) begin
            state_next = cnt == 8'd1 ? IDLE : FLASH;
            cnt_next = cnt - 8'd1;
        end
    end

    assign bus.out_valid = valid_d2;
    assign bus.out_within = in_box_d2 & (rom_data != TRANSPARENT);
    assign bus.out_rgb = bus.out_within ? (state == FLASH ? FLASH_COLOR : rom_data) : '0;
endmodule

// File: tb/tb_game_sprite_display.sv
// tb_game_sprite_display: directed and random raster stimulus against a frame-level sprite model.
module tb_game_sprite_display;
    import game_sprite_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    game_sprite_display_if bus();
    game_sprite_display dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    bit fs, pv, neg, hw;
    int px, py, sx, sy;
    int m_sx, m_sy, m_flash_left, p_col, e_col;
    bit m_flip, m_hit_prev, p_valid, p_within, e_valid, e_within;
    rgb_t e_rgb;

    function automatic int rom_px(int r, int c);
        if (c == 0) return 4;
        if (c == 7) return 1;
        if ((r + c) % 3 == 0) return 0;
        return (r * 3 + c) % 6 + 1;
    endfunction

    function automatic logic [4:0] got();
        return {bus.out_valid, bus.out_within, bus.out_rgb};
    endfunction

    function automatic logic [4:0] wanted();
        return {e_valid, e_within, e_rgb};
    endfunction

    task automatic model_reset();
        {m_sx, m_sy, m_flash_left, p_col, e_col} = '0;
        {m_flip, m_hit_prev, p_valid, p_within, e_valid, e_within} = '0;
        e_rgb = '0;
    endtask

    task automatic step();
        int rx, ry, c;
        bit inb;
        bus.frame_start = fs;
        bus.pix_valid = pv;
        bus.pix_x = w_x'(px);
        bus.pix_y = w_y'(py);
        bus.sprite_x = w_x'(sx);
        bus.sprite_y = w_y'(sy);
        bus.sprite_dx_neg = neg;
        bus.hit_wall = hw;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            e_valid = p_valid;
            e_within = p_within;
            e_col = p_col;
            rx = px - m_sx;
            ry = py - m_sy;
            inb = pv && rx >= 0 && ry >= 0 && rx < 8 && ry < 8;
`ifdef GAME_SPRITE_FLIP_EN
            c = m_flip ? 7 - rx : rx;
`else
            c = rx;
`endif
            p_valid = pv;
            p_col = inb ? rom_px(ry, c) : 0;
            p_within = inb && p_col != 0;
            if (fs) begin
                m_sx = sx;
                m_sy = sy;
                m_flip = neg;
            end
            if (hw && !m_hit_prev) m_flash_left = 8;
            else if (fs && m_flash_left > 0) m_flash_left--;
            m_hit_prev = hw;
            e_rgb = e_within ? (m_flash_left > 0 ? 3'd7 : 3'(e_col)) : 3'd0;
        end
        #1;
    endtask

    task automatic test_reset();
        {fs, pv, neg, hw} = '0;
        {px, py, sx, sy} = '0;
        model_reset();
        repeat (2) step();
        vectors++;
        if (got() !== 5'b0) begin miscompares++; $display("FAIL reset: got %b want 00000", got()); end
        rst = 1'b0;
        sx = 100; sy = 50; fs = 1; step(); fs = 0;
        for (int x = 98; x < 104; x++) begin pv = 1; px = x; py = 53; step(); end
        rst = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (got() !== 5'b0) begin miscompares++; $display("FAIL async_reset: got %b want 00000", got()); end
        repeat (3) begin
            step();
            vectors++;
            if (got() !== 5'b0) begin miscompares++; $display("FAIL reset_hold: got %b want 00000", got()); end
        end
        rst = 1'b0;
        px = 2; py = 3; step(); pv = 0;
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL release_lat1: got %b want 0", bus.out_valid); end
        step();
        vectors++;
        if (got() !== wanted() || bus.out_valid !== 1'b1)
            begin miscompares++; $display("FAIL release_lat2: got %b want %b", got(), wanted()); end
    endtask

    task automatic test_row();
        sx = 100; sy = 50; fs = 1; pv = 0; step(); fs = 0;
        for (int x = 98; x < 112; x++) begin
            pv = x < 110; px = x; py = 53; step();
            vectors++;
            if (got() !== wanted()) begin miscompares++; $display("FAIL row x=%0d: got %b want %b", x, got(), wanted()); end
        end
    endtask

    task automatic test_midframe();
        sx = 200;
        for (int i = 0; i < 2; i++) begin
            for (int x = 96; x < 212; x++) begin
                pv = (x < 112) || (x >= 196); px = x; py = 52; step();
                vectors++;
                if (got() !== wanted())
                    begin miscompares++; $display("FAIL midframe f=%0d x=%0d: got %b want %b", i, x, got(), wanted()); end
            end
            pv = 0; fs = 1; step(); fs = 0;
        end
    endtask

    task automatic test_corner();
        sx = 636; sy = 476; fs = 1; pv = 0; step(); fs = 0;
        for (int y = 474; y < 484; y++) begin
            for (int x = 630; x < 646; x++) begin
                pv = (x < 640) && (y < 480); px = x % 640; py = y % 480; step();
                vectors++;
                if (got() !== wanted())
                    begin miscompares++; $display("FAIL corner (%0d,%0d): got %b want %b", x, y, got(), wanted()); end
            end
        end
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 6; x++) begin
                pv = 1; px = x; py = y; step();
                vectors++;
                if (got() !== wanted() || (bus.out_within !== 1'b0 && x >= 2))
                    begin miscompares++; $display("FAIL nowrap (%0d,%0d): got %b want %b", x, y, got(), wanted()); end
            end
        end
        pv = 0;
    endtask

    task automatic test_flash();
        sx = 100; sy = 50; fs = 1; step(); fs = 0;
        hw = 1;
        for (int f = 0; f < 16; f++) begin
            if (f == 5) begin hw = 0; pv = 0; step(); hw = 1; end
            for (int x = 99; x < 111; x++) begin
                pv = x < 109; px = x; py = 51; step();
                vectors++;
                if (got() !== wanted())
                    begin miscompares++; $display("FAIL flash f=%0d x=%0d: got %b want %b", f, x, got(), wanted()); end
            end
            fs = 1; step(); fs = 0;
        end
        hw = 0;
    endtask

    task automatic test_flip();
        rgb_t want_col;
`ifdef GAME_SPRITE_FLIP_EN
        want_col = BLUE;
`else
        want_col = RED;
`endif
        sx = 300; sy = 200; neg = 1; fs = 1; step(); fs = 0;
        pv = 1; px = 300; py = 200; step(); pv = 0; step();
        vectors++;
        if (bus.out_rgb !== want_col || got() !== wanted())
            begin miscompares++; $display("FAIL flip: got rgb %0d want %0d", bus.out_rgb, want_col); end
        neg = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            fs = $urandom_range(0, 60) == 0;
            if (fs) begin
                sx = $urandom_range(0, 639);
                sy = $urandom_range(0, 479);
                neg = $urandom_range(0, 1);
            end
            if ($urandom_range(0, 150) == 0) hw = ~hw;
            pv = $urandom_range(0, 3) != 0;
            px = m_sx + $urandom_range(0, 15) - 4;
            py = m_sy + $urandom_range(0, 11) - 2;
            px = px < 0 ? 0 : (px > 639 ? 639 : px);
            py = py < 0 ? 0 : (py > 479 ? 479 : py);
            step();
            vectors++;
            if (got() !== wanted())
                begin miscompares++; $display("FAIL random i=%0d (%0d,%0d): got %b want %b", i, px, py, got(), wanted()); end
        end
    endtask

    initial begin
        test_reset();
        test_row();
        test_midframe();
        test_corner();
        test_flash();
        test_flip();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
